// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: serialises per-drive SD requests onto one host SD port, round-robin with a per-session lock
module sd_req_arbiter #(
  parameter int NUM_CH = 3,
  parameter int LBA_W  = 32,
  parameter int TMO_W  = 24
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_rd,
  input  logic [NUM_CH-1:0]       ch_wr,
  input  logic [NUM_CH*LBA_W-1:0] ch_lba,
  input  logic [NUM_CH*8-1:0]     ch_buff_din,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic                    host_rd,
  output logic                    host_wr,
  output logic [LBA_W-1:0]        host_lba,
  output logic [1:0]              host_drive,
  output logic [7:0]              host_buff_din,
  input  logic                    host_ack,
  output logic                    busy,
  output logic                    timeout_err
);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state, next_state;
  logic [1:0] sel, rr_ptr, pick;
  logic is_rd, ack_seen, old_ack;
  logic [TMO_W-1:0] tmo_cnt;
  logic [NUM_CH-1:0] req;
  logic req_sel, ack_edge, release_c, tmo_hit, stay;

  function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] r, input logic [1:0] p);
    int j;
    rr_pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(p) + k) % NUM_CH;
      if (r[j]) rr_pick = 2'(j);
    end
  endfunction

  assign req = ch_rd | ch_wr;
  assign pick = rr_pick(req, rr_ptr);
  // A session serves one direction; a pending write on a read session waits for its own session
  assign req_sel = is_rd ? ch_rd[sel] : ch_wr[sel];
  assign ack_edge = host_ack ^ old_ack;
  assign release_c = ~req_sel & ~host_ack & (old_ack | ~ack_seen);
  assign tmo_hit = (state == XFER) & (&tmo_cnt) & ~ack_edge;
  assign stay = next_state == XFER;
  assign host_buff_din = state == XFER ? ch_buff_din[sel*8 +: 8] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ack
    assign ch_ack[i] = (state == XFER) && (sel == 2'(i)) && host_ack;
  end

  always_comb begin
    next_state = state == IDLE ? (|req ? XFER : IDLE)
               : state == XFER ? (release_c || tmo_hit ? GAP : XFER)
               : IDLE;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel         <= '0;
      rr_ptr      <= '0;
      is_rd       <= 1'b0;
      ack_seen    <= 1'b0;
      old_ack     <= 1'b0;
      tmo_cnt     <= '0;
      host_rd     <= 1'b0;
      host_wr     <= 1'b0;
      host_lba    <= '0;
      host_drive  <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      old_ack     <= host_ack;
      timeout_err <= tmo_hit;
      if (state == IDLE && |req) begin
        sel      <= pick;
        is_rd    <= ch_rd[pick];
        busy     <= 1'b1;
        tmo_cnt  <= '0;
        ack_seen <= 1'b0;
      end
      if (state == XFER) begin
        tmo_cnt    <= ack_edge ? '0 : tmo_cnt + 1'b1;
        ack_seen   <= ack_seen | (host_ack & ~old_ack);
        host_rd    <= stay & is_rd & ch_rd[sel];
        host_wr    <= stay & ~is_rd & ch_wr[sel];
        host_lba   <= ch_lba[sel*LBA_W +: LBA_W];
        host_drive <= sel;
      end
      if (state == GAP) begin
        busy   <= 1'b0;
        rr_ptr <= sel == 2'(NUM_CH - 1) ? '0 : sel + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter: scenario tasks plus a randomized round-robin session model for sd_req_arbiter
module tb_sd_req_arbiter;
  logic        clk_sys, reset_n;
  logic [2:0]  ch_rd, ch_wr, ch_ack;
  logic [95:0] ch_lba;
  logic [23:0] ch_buff_din;
  logic        host_rd, host_wr, host_ack, busy, timeout_err;
  logic [31:0] host_lba;
  logic [1:0]  host_drive;
  logic [7:0]  host_buff_din;
  logic [31:0] lba [3];
  logic [7:0]  bufv [3];
  int errs = 0, checks = 0;

  assign ch_lba = {lba[2], lba[1], lba[0]};
  assign ch_buff_din = {bufv[2], bufv[1], bufv[0]};

  sd_req_arbiter #(.NUM_CH(3), .LBA_W(32), .TMO_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_lba(ch_lba),
    .ch_buff_din(ch_buff_din), .ch_ack(ch_ack), .host_rd(host_rd), .host_wr(host_wr),
    .host_lba(host_lba), .host_drive(host_drive), .host_buff_din(host_buff_din),
    .host_ack(host_ack), .busy(busy), .timeout_err(timeout_err));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk_sys);
  endtask

  task automatic do_reset;
    reset_n = 1'b0; ch_rd = '0; ch_wr = '0; host_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin lba[i] = '0; bufv[i] = '0; end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ch_rd = 3'b111; ch_wr = 3'b111; host_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin lba[i] = 32'hFFFF_FFFF; bufv[i] = 8'hFF; end
    repeat (3) tick();
    checks++; if ({host_rd, host_wr, busy, timeout_err} !== 4'b0) begin errs++; $display("FAIL reset_ctl: rd/wr/busy/tmo=%b want 0000", {host_rd, host_wr, busy, timeout_err}); end
    checks++; if (host_lba !== 32'h0 || host_drive !== 2'd0) begin errs++; $display("FAIL reset_addr: lba=%h drive=%0d want 0/0", host_lba, host_drive); end
    checks++; if (ch_ack !== 3'b000 || host_buff_din !== 8'h00) begin errs++; $display("FAIL reset_ack: ch_ack=%b buff=%h want 000/00", ch_ack, host_buff_din); end
  endtask

  task automatic test_single;
    do_reset();
    lba[0] = 32'h10; ch_rd = 3'b001;
    tick();
    checks++; if (busy !== 1'b1 || host_rd !== 1'b0) begin errs++; $display("FAIL single_grant: busy=%0b rd=%0b want 1/0", busy, host_rd); end
    tick();
    checks++; if (host_rd !== 1'b1 || host_lba !== 32'h10 || host_drive !== 2'd0) begin errs++; $display("FAIL single_req: rd=%0b lba=%h drive=%0d want 1/10/0", host_rd, host_lba, host_drive); end
    host_ack = 1'b1; #1;
    checks++; if (ch_ack !== 3'b001) begin errs++; $display("FAIL single_ack: ch_ack=%b want 001", ch_ack); end
    tick(); ch_rd = 3'b000;
    tick(); host_ack = 1'b0; #1;
    checks++; if (ch_ack !== 3'b000) begin errs++; $display("FAIL single_ackfall: ch_ack=%b want 000", ch_ack); end
    tick();
    checks++; if (host_rd !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL single_gap: rd=%0b busy=%0b want 0/1", host_rd, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_rr;
    bit saw_low = 0;
    do_reset();
    lba[0] = 32'h100; lba[2] = 32'h200; ch_rd = 3'b101;
    repeat (2) tick();
    checks++; if (host_drive !== 2'd0 || host_lba !== 32'h100) begin errs++; $display("FAIL rr_first: drive=%0d lba=%h want 0/100", host_drive, host_lba); end
    host_ack = 1'b1; #1;
    checks++; if (ch_ack !== 3'b001) begin errs++; $display("FAIL rr_ack: ch_ack=%b want 001", ch_ack); end
    tick(); ch_rd = 3'b100;
    tick(); host_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (host_rd) break; saw_low = 1; end
    checks++; if (host_rd !== 1'b1 || host_drive !== 2'd2 || host_lba !== 32'h200 || !saw_low) begin errs++; $display("FAIL rr_second: rd=%0b drive=%0d lba=%h gap=%0b want 1/2/200/1", host_rd, host_drive, host_lba, saw_low); end
  endtask

  task automatic test_multi;
    bit rd_drop = 0;
    do_reset();
    lba[1] = 32'h1A; ch_rd = 3'b010;
    repeat (2) tick();
    ch_rd = 3'b011;
    for (int s = 0; s < 13; s++) begin
      lba[1] = 32'h1A + 32'(s);
      tick();
      checks++; if (host_rd !== 1'b1 || host_drive !== 2'd1 || host_lba !== 32'h1A + 32'(s)) begin errs++; $display("FAIL multi_sec%0d: rd=%0b drive=%0d lba=%h want 1/1/%h", s, host_rd, host_drive, host_lba, 32'h1A + 32'(s)); end
      host_ack = 1'b1; #1;
      checks++; if (ch_ack !== 3'b010) begin errs++; $display("FAIL multi_ack%0d: ch_ack=%b want 010", s, ch_ack); end
      if (s == 12) ch_rd = 3'b001;
      tick(); if (s < 12) rd_drop |= ~host_rd;
      tick(); if (s < 12) rd_drop |= ~host_rd;
      host_ack = 1'b0;
      tick(); if (s < 12) rd_drop |= ~host_rd;
    end
    checks++; if (rd_drop) begin errs++; $display("FAIL multi_lock: host_rd dropped between sectors got 1 want 0"); end
    for (int i = 0; i < 10; i++) begin if (host_rd) break; tick(); end
    checks++; if (host_rd !== 1'b1 || host_drive !== 2'd0) begin errs++; $display("FAIL multi_next: rd=%0b drive=%0d want 1/0", host_rd, host_drive); end
  endtask

  task automatic test_timeout;
    int n = 0;
    do_reset();
    ch_rd = 3'b100;
    tick();
    for (int i = 0; i < 40; i++) begin tick(); if (timeout_err) break; n += int'(host_rd); end
    checks++; if (timeout_err !== 1'b1 || n != 15 || host_rd !== 1'b0) begin errs++; $display("FAIL tmo_pulse: err=%0b rd_cycles=%0d rd=%0b want 1/15/0", timeout_err, n, host_rd); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL tmo_width: err=%0b want 0", timeout_err); end
    for (int i = 0; i < 10; i++) begin if (host_rd) break; tick(); end
    checks++; if (host_rd !== 1'b1 || host_drive !== 2'd2) begin errs++; $display("FAIL tmo_regrant: rd=%0b drive=%0d want 1/2", host_rd, host_drive); end
  endtask

  task automatic test_rdwr;
    bit saw_low = 0;
    do_reset();
    checks++; if (host_buff_din !== 8'h00) begin errs++; $display("FAIL rdwr_idlebuf: buff=%h want 00", host_buff_din); end
    bufv[0] = 8'hA5; ch_rd = 3'b001; ch_wr = 3'b001;
    repeat (2) tick();
    checks++; if (host_rd !== 1'b1 || host_wr !== 1'b0) begin errs++; $display("FAIL rdwr_rdfirst: rd=%0b wr=%0b want 1/0", host_rd, host_wr); end
    host_ack = 1'b1;
    tick(); ch_rd = 3'b000;
    tick(); host_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (host_wr) break; saw_low = 1; end
    checks++; if (host_wr !== 1'b1 || host_rd !== 1'b0 || host_drive !== 2'd0 || host_buff_din !== 8'hA5 || !saw_low) begin errs++; $display("FAIL rdwr_wr: wr=%0b rd=%0b drive=%0d buff=%h gap=%0b want 1/0/0/a5/1", host_wr, host_rd, host_drive, host_buff_din, saw_low); end
    host_ack = 1'b1; #1;
    checks++; if (ch_ack !== 3'b001) begin errs++; $display("FAIL rdwr_ack: ch_ack=%b want 001", ch_ack); end
    ch_wr = 3'b000;
    tick(); host_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (!busy) break; end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rdwr_end: busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    ch_rd = 3'b001;
    repeat (2) tick();
    host_ack = 1'b1;
    tick();
    checks++; if (ch_ack !== 3'b001) begin errs++; $display("FAIL rmid_ack: ch_ack=%b want 001", ch_ack); end
    ch_rd = 3'b010;
    #2 reset_n = 1'b0; #1;
    checks++; if (host_rd !== 1'b0 || ch_ack !== 3'b000 || busy !== 1'b0) begin errs++; $display("FAIL rmid_drop: rd=%0b ch_ack=%b busy=%0b want 0/000/0", host_rd, ch_ack, busy); end
    host_ack = 1'b0;
    tick(); reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (host_rd) break; end
    checks++; if (host_rd !== 1'b1 || host_drive !== 2'd1) begin errs++; $display("FAIL rmid_regrant: rd=%0b drive=%0d want 1/1", host_rd, host_drive); end
  endtask

  // Round-robin model: pending channels are served in cyclic order starting at the pointer
  task automatic test_random;
    int ptr = 0, order[$];
    logic [2:0] mask, isw;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      mask = 3'($urandom_range(1, 7));
      isw = 3'($urandom_range(0, 7));
      order.delete();
      for (int k = 0; k < 3; k++) if (mask[(ptr + k) % 3]) order.push_back((ptr + k) % 3);
      for (int c = 0; c < 3; c++) begin lba[c] = $urandom; bufv[c] = 8'($urandom_range(0, 255)); end
      ch_rd = mask & ~isw; ch_wr = mask & isw;
      foreach (order[q]) begin
        int c = order[q];
        bit saw_low = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (host_rd || host_wr) break; saw_low = 1; end
        checks++; if (host_drive !== 2'(c) || host_lba !== lba[c] || host_rd !== ~isw[c] || host_wr !== isw[c] || !saw_low) begin errs++; $display("FAIL rand_grant%0d: drive=%0d lba=%h rd=%0b wr=%0b gap=%0b want %0d/%h/%0b/%0b/1", it, host_drive, host_lba, host_rd, host_wr, saw_low, c, lba[c], ~isw[c], isw[c]); end
        checks++; if (host_buff_din !== bufv[c]) begin errs++; $display("FAIL rand_buf%0d: buff=%h want %h", it, host_buff_din, bufv[c]); end
        host_ack = 1'b1; #1;
        checks++; if (ch_ack !== 3'(1 << c)) begin errs++; $display("FAIL rand_ack%0d: ch_ack=%b want %b", it, ch_ack, 3'(1 << c)); end
        ch_rd[c] = 1'b0; ch_wr[c] = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        host_ack = 1'b0;
        ptr = (c + 1) % 3;
      end
      for (int i = 0; i < 10; i++) begin tick(); if (!busy) break; end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rand_idle%0d: busy=%0b want 0", it, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_multi();
    test_timeout();
    test_rdwr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
